// File: rtl/axi_sram_slave_bridge.sv
// AXI4 slave bridging one AXI port onto a single-port synchronous SRAM.
// One transaction at a time; reads and writes share the SRAM port under round-robin arbitration.
module axi_sram_slave_bridge #(
    parameter int ID_W       = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 4,
    parameter int MEM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  ARSTN,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [LEN_W-1:0]      AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_W-1:0]       ARID,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [LEN_W-1:0]      ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_bweb,
    output logic [DATA_W-1:0]     mem_di,
    input  logic [DATA_W-1:0]     mem_do
);

    localparam int OFF    = $clog2(DATA_W / 8);
    localparam int STRB_W = DATA_W / 8;

    // state    | meaning
    // S_IDLE   | arbitrate AW/AR, latch the granted request
    // S_WDATA  | accept W beats, one SRAM write per beat
    // S_WRESP  | present B response
    // S_RISSUE | issue SRAM read for the current beat
    // S_RVALID | present R beat from mem_do
    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RISSUE, S_RVALID} state_e;

    state_e                state_q, state_d;
    logic                  prio_wr_q, prio_wr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;
    logic                  rerr_q, rerr_d;

    logic aw_gnt;
    logic ar_gnt;
    logic last_beat;

    // Address bits outside the word field are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR, ARADDR};

    function automatic logic calc_err(input logic [LEN_W-1:0] len,
                                      input logic [2:0] size,
                                      input logic [1:0] burst);
        logic [31:0] l;
        logic        wrap_ok;
        l       = 32'(len);
        wrap_ok = (l == 32'd1) || (l == 32'd3) || (l == 32'd7) || (l == 32'd15);
        return (size != 3'(OFF)) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    endfunction

    // WRAP lengths are 2^n-1, so len itself is the mask of the wrapping low bits.
    function automatic logic [MEM_ADDR_W-1:0] next_addr(input logic [MEM_ADDR_W-1:0] a,
                                                        input logic [LEN_W-1:0] len,
                                                        input logic [1:0] burst);
        logic [MEM_ADDR_W-1:0] mask;
        logic [MEM_ADDR_W-1:0] inc;
        mask = MEM_ADDR_W'(len);
        inc  = a + MEM_ADDR_W'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    assign aw_gnt    = AWVALID && (!ARVALID || prio_wr_q);
    assign ar_gnt    = ARVALID && !aw_gnt;
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        err_d     = err_q;
        rerr_d    = rerr_q;
        AWREADY   = 1'b0;
        ARREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BID       = '0;
        BRESP     = 2'b00;
        RVALID    = 1'b0;
        RID       = '0;
        RDATA     = '0;
        RRESP     = 2'b00;
        RLAST     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_di    = WDATA;
        mem_bweb  = '1;

        case (state_q)
            S_IDLE: begin
                AWREADY = aw_gnt && !ARSTN;
                ARREADY = ar_gnt && !ARSTN;
                if (aw_gnt) begin
                    id_d      = AWID;
                    addr_d    = AWADDR[OFF +: MEM_ADDR_W];
                    len_d     = AWLEN;
                    burst_d   = AWBURST;
                    err_d     = calc_err(AWLEN, AWSIZE, AWBURST);
                    rerr_d    = 1'b0;
                    cnt_d     = '0;
                    prio_wr_d = 1'b0;
                    state_d   = S_WDATA;
                end else if (ar_gnt) begin
                    id_d      = ARID;
                    addr_d    = ARADDR[OFF +: MEM_ADDR_W];
                    len_d     = ARLEN;
                    burst_d   = ARBURST;
                    err_d     = calc_err(ARLEN, ARSIZE, ARBURST);
                    cnt_d     = '0;
                    prio_wr_d = 1'b1;
                    state_d   = S_RISSUE;
                end
            end
            S_WDATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    mem_en = !err_q;
                    mem_we = 1'b1;
                    for (int i = 0; i < STRB_W; i++) begin
                        mem_bweb[8*i +: 8] = {8{~WSTRB[i]}};
                    end
                    if (WLAST != last_beat) begin
                        rerr_d = 1'b1;
                    end
                    addr_d = next_addr(addr_q, len_q, burst_q);
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                BVALID = 1'b1;
                BID    = id_q;
                BRESP  = (err_q || rerr_q) ? 2'b10 : 2'b00;
                if (BREADY) begin
                    state_d = S_IDLE;
                end
            end
            S_RISSUE: begin
                mem_en  = !err_q;
                state_d = S_RVALID;
            end
            S_RVALID: begin
                RVALID = 1'b1;
                RID    = id_q;
                RDATA  = err_q ? '0 : mem_do;
                RRESP  = err_q ? 2'b10 : 2'b00;
                RLAST  = last_beat;
                if (RREADY) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = next_addr(addr_q, len_q, burst_q);
                        cnt_d   = cnt_q + LEN_W'(1);
                        state_d = S_RISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ARSTN) begin
        if (ARSTN) begin
            state_q   <= S_IDLE;
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= 2'b00;
            err_q     <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            rerr_q    <= rerr_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave_bridge.sv
// Scoreboard bench for axi_sram_slave_bridge: expectations are queued at issue time from a
// word-level memory model and checked by a monitor whenever the DUT presents B, R or an SRAM access.
module tb_axi_sram_slave_bridge;

    logic        clk = 1'b0;
    logic        ARSTN = 1'b1;
    logic [7:0]  AWID = '0, ARID = '0, BID, RID;
    logic [31:0] AWADDR = '0, ARADDR = '0;
    logic [3:0]  AWLEN = '0, ARLEN = '0;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0;
    logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic        AWVALID = 1'b0, ARVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0;
    logic        AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST;
    logic        BREADY = 1'b0, RREADY = 1'b0;
    logic [31:0] WDATA = '0, RDATA;
    logic [3:0]  WSTRB = '0;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_bweb, mem_di, mem_do;

    axi_sram_slave_bridge dut (
        .clk(clk), .ARSTN(ARSTN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_bweb(mem_bweb),
        .mem_di(mem_di), .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [13:0] addr; logic [31:0] di; logic [31:0] bweb; } mem_t;
    typedef struct { logic [7:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;

    mem_t        memq[$];
    b_t          bq[$];
    r_t          rq[$];
    logic [31:0] sram    [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          rr_rand = 1'b0, br_rand = 1'b0, rr_force = 1'b1, br_force = 1'b1;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
    endfunction

    // SRAM macro: write-through with active-low bit enables, registered read data held between reads.
    initial for (int i = 0; i < 16384; i++) sram[i] <= init_word(i);
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= (sram[mem_addr] & mem_bweb) | (mem_di & ~mem_bweb);
            else        mem_do <= sram[mem_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        RREADY = rr_rand ? ($urandom_range(0, 2) != 0) : rr_force;
        BREADY = br_rand ? ($urandom_range(0, 2) != 0) : br_force;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_err(input int len, input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic logic [13:0] beat_addr(input logic [13:0] s, input int len,
                                              input logic [1:0] burst, input int k);
        int n, base;
        n    = len + 1;
        base = int'(s) - int'(s) % n;
        case (burst)
            2'b00:   return s;
            2'b10:   return 14'(base + (int'(s) % n + k) % n);
            default: return 14'(int'(s) + k);
        endcase
    endfunction

    function automatic logic [31:0] bweb_of(input logic [3:0] s);
        logic [31:0] b;
        for (int i = 0; i < 4; i++) b[8*i +: 8] = s[i] ? 8'h00 : 8'hFF;
        return b;
    endfunction

    function automatic logic sig(input int which);
        case (which)
            0: return AWREADY;
            1: return ARREADY;
            2: return WREADY;
            3: return BVALID;
            4: return RVALID;
            default: return AWREADY | ARREADY;
        endcase
    endfunction

    task automatic wait_for(input int which, output int t);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sig(which)) begin ok = 1'b1; break; end
        end
        if (!ok) chk($sformatf("timeout_sig%0d", which), 64'(ok), 64'd1);
        t = cyc;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 600; n++) begin
            if (memq.size() == 0 && bq.size() == 0 && rq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(memq.size() + bq.size() + rq.size()), 64'd0);
        memq.delete(); bq.delete(); rq.delete();
        @(posedge clk); #1;
    endtask

    task automatic push_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst, input int bad_beat);
        mem_t m; b_t b; bit err, rerr; logic [13:0] a;
        err  = is_err(len, size, burst);
        rerr = err;
        for (int k = 0; k <= len; k++) begin
            if (k == bad_beat) rerr = 1'b1;
            if (!err) begin
                a = beat_addr(addr[15:2], len, burst, k);
                m.we = 1'b1; m.addr = a; m.di = wd[k]; m.bweb = bweb_of(ws[k]);
                memq.push_back(m);
                for (int i = 0; i < 4; i++) if (ws[k][i]) ref_mem[a][8*i +: 8] = wd[k][8*i +: 8];
            end
        end
        b.id = id; b.resp = rerr ? 2'b10 : 2'b00;
        bq.push_back(b);
    endtask

    task automatic push_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
        mem_t m; r_t r; bit err; logic [13:0] a;
        err = is_err(len, size, burst);
        for (int k = 0; k <= len; k++) begin
            a = beat_addr(addr[15:2], len, burst, k);
            if (!err) begin
                m.we = 1'b0; m.addr = a; m.di = '0; m.bweb = '1;
                memq.push_back(m);
            end
            r.id = id; r.data = err ? 32'h0 : ref_mem[a]; r.resp = err ? 2'b10 : 2'b00;
            r.last = (k == len);
            rq.push_back(r);
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                            input bit gaps);
        int t, t2; bit gapped;
        gapped = 1'b0;
        push_write(id, addr, len, size, burst, bad_beat);
        @(posedge clk); #1;
        AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        wait_for(0, t);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                gapped = 1'b1; WVALID = 1'b0;
                @(posedge clk); #1;
            end
            WVALID = 1'b1; WDATA = wd[k]; WSTRB = ws[k];
            WLAST = (k == len) ^ (k == bad_beat);
            wait_for(2, t2);
            @(posedge clk); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        if (!gapped) begin
            wait_for(3, t2);
            chk("b_latency", 64'(t2 - t), 64'(len + 2));
        end
        wait_drain();
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t, t2;
        push_read(id, addr, len, size, burst);
        @(posedge clk); #1;
        ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        wait_for(1, t);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        wait_for(4, t2);
        chk("r_latency", 64'(t2 - t), 64'd2);
        wait_drain();
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_ctl"}, 64'({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, mem_en, mem_we}), 64'd0);
        chk({tag, "_ids"}, 64'({BID, RID, BRESP, RRESP}), 64'd0);
        chk({tag, "_rdata"}, 64'(RDATA), 64'd0);
        chk({tag, "_bweb"}, 64'(mem_bweb), 64'hFFFF_FFFF);
    endtask

    mem_t mm;
    b_t   bb;
    r_t   rr;
    always @(negedge clk) begin
        if (!ARSTN) begin
            if (mem_en) begin
                if (memq.size() == 0) chk("mem_unexpected_access", 64'(mem_en), 64'd0);
                else begin
                    mm = memq.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(mm.we));
                    chk("mem_addr", 64'(mem_addr), 64'(mm.addr));
                    if (mm.we) begin
                        chk("mem_bweb", 64'(mem_bweb), 64'(mm.bweb));
                        chk("mem_di", 64'(mem_di & ~mem_bweb), 64'(mm.di & ~mm.bweb));
                    end
                end
            end
            if (BVALID && BREADY) begin
                if (bq.size() == 0) chk("b_unexpected", 64'(BVALID), 64'd0);
                else begin
                    bb = bq.pop_front();
                    chk("bid_bresp", 64'({BID, BRESP}), 64'({bb.id, bb.resp}));
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) chk("r_unexpected", 64'(RVALID), 64'd0);
                else begin
                    rr = rq.pop_front();
                    chk("rdata", 64'(RDATA), 64'(rr.data));
                    chk("rid_rresp_rlast", 64'({RID, RRESP, RLAST}), 64'({rr.id, rr.resp, rr.last}));
                end
            end
        end
    end

    initial begin
        #200000;
        chk("watchdog", 64'd1, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t2;
        logic [31:0] held;
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
        #2;
        check_rst("rst_init");
        @(posedge clk); @(posedge clk); #1;
        ARSTN = 1'b0;

        // single write then read
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(8'h01, 32'h40, 0, 3'd2, 2'b01, -1, 1'b0);
        do_read(8'h02, 32'h40, 0, 3'd2, 2'b01);
        chk("model_deadbeef", 64'(ref_mem[14'h10]), 64'hDEAD_BEEF);

        // INCR 4 beats with a half-word strobe on beat 2
        for (int k = 0; k < 4; k++) begin wd[k] = 32'h1111_1111 * (k + 1); ws[k] = 4'hF; end
        ws[2] = 4'h3;
        do_write(8'h03, 32'h100, 3, 3'd2, 2'b01, -1, 1'b0);
        do_read(8'h04, 32'h100, 3, 3'd2, 2'b01);

        // WRAP read 6,7,4,5
        do_read(8'h05, 32'h18, 3, 3'd2, 2'b10);

        // error cases
        wd[0] = 32'hCAFE_0000; ws[0] = 4'hF;
        do_write(8'h06, 32'h200, 0, 3'd1, 2'b01, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(8'h07, 32'h300, 2, 3'd2, 2'b01, 1, 1'b0);
        do_read(8'h08, 32'h300, 2, 3'd2, 2'b11);
        do_read(8'h09, 32'h300, 2, 3'd2, 2'b01);

        // read backpressure mid-burst
        push_read(8'h0A, 32'h100, 3, 3'd2, 2'b01);
        @(posedge clk); #1;
        ARID = 8'h0A; ARADDR = 32'h100; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        wait_for(1, t);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        wait_for(4, t2);
        rr_force = 1'b0;
        @(posedge clk);
        wait_for(4, t2);
        held = RDATA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rdata_stable", 64'(RDATA), 64'(held));
            chk("bp_hold", 64'({RVALID, mem_en}), 64'b10);
        end
        rr_force = 1'b1;
        wait_drain();

        // reset mid-write
        @(posedge clk); #1;
        AWID = 8'h5A; AWADDR = 32'h2000; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        wait_for(0, t);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mm.we = 1'b1; mm.addr = 14'h800 + 14'(k); mm.di = 32'hAB00_0000 + 32'(k); mm.bweb = '0;
            memq.push_back(mm);
            ref_mem[14'h800 + 14'(k)] = mm.di;
            WVALID = 1'b1; WDATA = mm.di; WSTRB = 4'hF; WLAST = 1'b0;
            wait_for(2, t2);
            @(posedge clk); #1;
        end
        WDATA = 32'hBAD0_BAD0; AWVALID = 1'b1; ARVALID = 1'b1;
        #2 ARSTN = 1'b1;
        #1 check_rst("rst_mid");
        AWVALID = 1'b0; ARVALID = 1'b0; WVALID = 1'b0;
        chk("rst_mid_queues", 64'(memq.size() + bq.size()), 64'd0);
        memq.delete(); bq.delete(); rq.delete();
        @(posedge clk); @(posedge clk); #1;
        ARSTN = 1'b0;

        // arbitration straight out of reset: W, R, W, R
        wd[0] = 32'hA5A5_0001; ws[0] = 4'hF;
        @(posedge clk); #1;
        AWID = 8'h11; AWADDR = 32'h800; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        ARID = 8'h22; ARADDR = 32'h900; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_for(5, t);
            chk("arb_order", 64'({AWREADY, ARREADY}), (g % 2 == 0) ? 64'b10 : 64'b01);
            if (AWREADY) begin
                push_write(8'h11, 32'h800, 0, 3'd2, 2'b01, -1);
                @(posedge clk); #1;
                if (g == 3) begin AWVALID = 1'b0; ARVALID = 1'b0; end
                WVALID = 1'b1; WDATA = wd[0]; WSTRB = 4'hF; WLAST = 1'b1;
                wait_for(2, t2);
                @(posedge clk); #1;
                WVALID = 1'b0; WLAST = 1'b0;
                wait_for(3, t2);
                @(posedge clk);
            end else begin
                push_read(8'h22, 32'h900, 0, 3'd2, 2'b01);
                @(posedge clk); #1;
                if (g == 3) begin AWVALID = 1'b0; ARVALID = 1'b0; end
                wait_for(4, t2);
                @(posedge clk);
            end
        end
        wait_drain();
        do_read(8'h23, 32'h2000, 3, 3'd2, 2'b01);

        // randomized traffic with random B/R backpressure and W gaps
        rr_rand = 1'b1; br_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int len, r, bad;
            logic [1:0]  burst;
            logic [2:0]  size;
            logic [31:0] addr;
            len   = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 7);
            r     = $urandom_range(0, 9);
            burst = (r == 0) ? 2'b00 : (r <= 5) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            addr  = {16'($urandom), 14'($urandom_range(0, 63)), 2'($urandom)};
            bad   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
            for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
            if ($urandom_range(0, 1) == 0)
                do_write(8'($urandom), addr, len, size, burst, bad, 1'b1);
            else
                do_read(8'($urandom), addr, len, size, burst);
        end
        rr_rand = 1'b0; br_rand = 1'b0;
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave_bridge.md
# axi_sram_slave_bridge

Parametrised AXI4 slave that bridges one AXI port from the interconnect to a single-port synchronous SRAM macro. It is the generalised successor to the per-memory slave wrappers. It has configurable data, address, ID and length widths, and supports FIXED/INCR/WRAP bursts with error responses and round-robin read/write arbitration. One transaction is in flight at a time, and the single SRAM port is shared by reads and writes.

## Interface
- ID_W, 8, AXI ID width
- ADDR_W, 32, AXI address width
- DATA_W, 32, data width; power of two, ≥ 16
- LEN_W, 4, burst length field width
- MEM_ADDR_W, 14, SRAM word-address width
- clk  in  1  clock
- ARSTN  in  1  reset, asynchronous, active-high
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/LEN_W/3/2  write address
- AWVALID in 1; AWREADY out 1
- WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data
- WVALID in 1; WREADY out 1
- BID/BRESP  out  ID_W/2  write response
- BVALID out 1; BREADY in 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/LEN_W/3/2  read address
- ARVALID in 1; ARREADY out 1
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data
- RVALID out 1; RREADY in 1
- mem_en  out  1  SRAM access enable (active-high)
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  MEM_ADDR_W  word address
- mem_bweb  out  DATA_W  per-bit write enable, active-low
- mem_di  out  DATA_W  write data
- mem_do  in  DATA_W  read data; valid the cycle after a read, held until the next access

## Operation
- Byte offset OFF = log2(DATA_W/8). Word address = addr[OFF+MEM_ADDR_W-1:OFF]. Upper address bits are ignored.
- States: IDLE, WDATA, WRESP, RISSUE, RVALID.
- IDLE arbitration:
  - AWREADY/ARREADY are asserted only in IDLE, and only for the granted side.
  - Only one valid: grant that side.
  - Both valid: grant the side not granted last (round-robin pointer). The pointer is "write" after reset.
  - The handshake latches ID, word address, len, burst and the error flag.
  - Transitions: IDLE→WDATA on a write grant, IDLE→RISSUE on a read grant.
- Error flag is set when any of these holds:
  - size ≠ OFF;
  - burst = 2'b11;
  - burst = WRAP and len ∉ {1,3,7,15}.
- WDATA:
  - WREADY=1.
  - Each W handshake drives mem_en=~err, mem_we=1, mem_di=WDATA, mem_bweb[8i+7:8i]=~{8{WSTRB[i]}}.
  - Each beat increments the beat counter.
  - WLAST is compared with (count==len). On any mismatch, set the sticky resp-error flag; the data is still written.
  - After beat len: go to WRESP.
- WRESP: BVALID=1, BID=latched ID. BRESP=2'b10 if err or the resp-error flag is set, else 2'b00. On BREADY, return to IDLE.
- RISSUE: mem_en=~err, mem_we=0, mem_addr=current address. Next state is RVALID.
- RVALID:
  - RVALID=1, RID=latched ID, RDATA = err ? 0 : mem_do, RRESP = err ? 2'b10 : 2'b00, RLAST=(count==len).
  - On RREADY with RLAST: go to IDLE. Otherwise advance the address and go to RISSUE.
- Address advance per beat:
  - FIXED: unchanged.
  - INCR: +1, wraps modulo 2^MEM_ADDR_W.
  - WRAP: low log2(len+1) bits increment modulo len+1; high bits are unchanged.
- mem_en=0 in every state and cycle not listed above. mem_addr/mem_di/mem_bweb are don't-care when mem_en=0.

## Timing
- Reset (ARSTN=1, asynchronous):
  - State=IDLE, counters=0, arbitration pointer=write.
  - AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, mem_en, mem_we = 0.
  - BID, RID, RDATA, BRESP, RRESP = 0.
  - mem_bweb = all ones.
  - Reset mid-burst drops the transaction; no response is issued.
- AWREADY/ARREADY are combinational from state, pointer and the VALIDs. No combinational path exists from the R/W/B READYs to the A*READY outputs.
- Write burst of N beats:
  - The AW handshake is at cycle t. WREADY is high from t+1.
  - With WVALID held high, beats complete at t+1 … t+N, with one SRAM write per beat in the same cycle.
  - BVALID at t+N+1.
- Read burst:
  - AR handshake at t. SRAM read issued at t+1. RVALID at t+2.
  - Each RREADY handshake is followed by the next RISSUE, giving 2 cycles per beat at full throughput.
  - RDATA/RID/RRESP/RLAST stay stable while RVALID=1 and RREADY=0.
- A new grant is possible on the cycle after the final B or R handshake, which is back in IDLE.

## Test plan
- Single write then read: AWADDR=0x40, len=0, INCR, WDATA=0xDEADBEEF, WSTRB=0xF → BRESP=0. Then AR 0x40 → RDATA=0xDEADBEEF, RLAST=1, RVALID at AR handshake +2.
- INCR write of 4 beats to 0x100, with WSTRB=0x3 on beat 2 → on readback, beat 2 upper half keeps its old value. mem_addr sequence is 0x40, 0x41, 0x42, 0x43.
- WRAP read: len=3, ARADDR=0x18 → word addresses 6, 7, 4, 5, with RLAST only on the 4th beat.
- Simultaneous AWVALID and ARVALID from reset → write granted first. Both held valid → the read is granted next, then write, alternating.
- Error cases:
  - AWSIZE=1 → no mem_en, BRESP=2'b10.
  - WLAST asserted on beat 1 of a len=2 burst → data is written, BRESP=2'b10.
  - ARBURST=2'b11 → all beats RDATA=0, RRESP=2'b10.
- Backpressure: RREADY low for 5 cycles mid-burst → RDATA stable and no extra mem_en. ARSTN pulsed mid-write → all outputs reach their reset values asynchronously, and the next transaction completes normally.
